// File: rtl/shift_pkg.sv
// Shared encodings for the shift execute unit: op codes, FSM states and constants.
package shift_pkg;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    SHOP_SLL = 2'b00,
    SHOP_SRL = 2'b01,
    SHOP_SRA = 2'b10,
    SHOP_ROL = 2'b11
  } shop_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS1 = 2'b01,
    PASS2 = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/shifter.sv
// 32-bit logical shifter: dir=1 shifts left, dir=0 shifts right, zero fill both ways.
module shifter (
  input  logic [31:0] data,
  input  logic        dir,
  input  logic [4:0]  shift,
  output logic [31:0] sh_out
);

  assign sh_out = dir ? (data << shift) : (data >> shift);

endmodule

// File: rtl/shift_exec_unit.sv
// Execute-stage shift sequencer: builds SLL/SRL/SRA/ROL from one or two passes
// through a logical left/right shifter, with valid/ready on issue and writeback.
module shift_exec_unit
  import shift_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_data,
  input  logic [4:0]       in_shamt,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd
);

  state_e            state_q, state_d;
  shop_e             op_q;
  logic [XLEN-1:0]   data_q;
  logic [4:0]        shamt_q;
  logic [TAG_W-1:0]  rd_q;
  logic [XLEN-1:0]   acc;

  logic [31:0]       sh_data;
  logic              sh_dir;
  logic [4:0]        sh_amt;
  logic [31:0]       sh_out;
  logic              need_pass2;

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign out_result = acc;
  assign out_rd     = rd_q;

  // Only arithmetic right shifts of negatives and non-trivial rotates need a fix-up pass.
  assign need_pass2 = (shamt_q != 5'd0) &&
                      (((op_q == SHOP_SRA) && data_q[31]) || (op_q == SHOP_ROL));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = PASS1;
      PASS1:   state_d = need_pass2 ? PASS2 : DONE;
      PASS2:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Second pass: SRA shifts all-ones right to build the sign-fill mask,
  // ROL shifts the operand right by (32 - shamt) to recover the wrapped bits.
  always_comb begin
    sh_data = data_q;
    sh_dir  = (op_q == SHOP_SLL) || (op_q == SHOP_ROL);
    sh_amt  = shamt_q;
    if (state_q == PASS2) begin
      sh_dir = 1'b0;
      if (op_q == SHOP_SRA) sh_data = ALL_ONES;
      else                  sh_amt  = 5'(6'd32 - {1'b0, shamt_q});
    end
  end

  shifter u_shifter (
    .data   (sh_data),
    .dir    (sh_dir),
    .shift  (sh_amt),
    .sh_out (sh_out)
  );

  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && in_valid && !rst) begin
      op_q    <= shop_e'(in_op);
      data_q  <= in_data;
      shamt_q <= in_shamt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      rd_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (in_valid) rd_q <= in_rd;
        PASS1:   acc <= sh_out;
        PASS2:   acc <= (op_q == SHOP_SRA) ? (acc | ~sh_out) : (acc | sh_out);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_exec_unit.sv
// Scoreboard bench for shift_exec_unit: directed and random ops against a plain-arithmetic model.
module tb_shift_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   holding = 1'b0;
  bit   rand_ready = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  shift_exec_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] x, input int s);
    logic signed [31:0] sx;
    sx = x;
    case (op)
      2'd0:    return x << s;
      2'd1:    return x >> s;
      2'd2:    return sx >>> s;
      default: return (s == 0) ? x : ((x << s) | (x >> (32 - s)));
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] x, input int s);
    if (s != 0 && ((op == 2'd2 && x[31]) || op == 2'd3)) return 3;
    return 2;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
    exp_t e;
    int   waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    in_rd    = rd;
    waited   = 0;
    while (!in_ready) begin
      if (waited > 100) begin
        chk("issue_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      waited++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    e.res     = exp_res;
    e.rd      = rd;
    e.lat     = exp_lat;
    e.acc_cyc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_rd    = 5'($urandom);
  endtask

  task automatic issue_rand();
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
    op = 2'($urandom);
    d  = $urandom;
    case ($urandom % 6)
      0:       s = 5'd0;
      1:       s = 5'd31;
      default: s = 5'($urandom);
    endcase
    if ($urandom % 4 == 0) d[31] = 1'b1;
    issue(op, d, s, 5'($urandom), ref_shift(op, d, int'(s)), ref_lat(op, d, int'(s)));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || holding) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops on the first cycle of each output, then checks it holds until taken.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!holding) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          cur = sb.pop_front();
          holding = 1'b1;
          chk("out_result", out_result, cur.res);
          chk("out_rd", 32'(out_rd), 32'(cur.rd));
          chk("latency", 32'(cyc - cur.acc_cyc + 1), 32'(cur.lat));
        end
      end else begin
        chk("hold_result", out_result, cur.res);
        chk("hold_rd", 32'(out_rd), 32'(cur.rd));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      if (out_ready) holding = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_data = '0; in_shamt = '0; in_rd = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    rand_ready = 1'b1;
    issue(2'd0, 32'h0000_0001, 5'd31, 5'd7,  32'h8000_0000, 2);
    issue(2'd2, 32'h8000_0000, 5'd4,  5'd3,  32'hF800_0000, 3);
    issue(2'd2, 32'h7000_0000, 5'd4,  5'd4,  32'h0700_0000, 2);
    issue(2'd3, 32'h8000_0001, 5'd1,  5'd5,  32'h0000_0003, 3);
    issue(2'd3, 32'h1234_5678, 5'd0,  5'd6,  32'h1234_5678, 2);
    issue(2'd1, 32'hFFFF_FFFF, 5'd0,  5'd8,  32'hFFFF_FFFF, 2);
    issue(2'd1, 32'hFFFF_FFFF, 5'd31, 5'd9,  32'h0000_0001, 2);
    drain();

    // Backpressure: hold out_ready low while in_valid toggles.
    rand_ready = 1'b0;
    @(posedge clk); #1; out_ready = 1'b0;
    issue(2'd2, 32'h8123_4567, 5'd8, 5'd17, 32'hFF81_2345, 3);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      in_data  = $urandom;
      in_rd    = 5'($urandom);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    repeat (4) @(posedge clk);
    drain();

    // Reset during PASS2 of an SRA: the operation must vanish.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd2; in_data = 32'h8000_0000; in_shamt = 5'd4; in_rd = 5'd12;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    chk("midrst_out_rd", 32'(out_rd), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clk);

    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) issue_rand();
    drain();
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
